// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer with redirect handshake, load-use scoreboard, mem watchdog
module pipe_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_rs1_request,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs2_request,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_rd_write,
    input  logic                  id_rd_load,
    input  logic                  ex_mispredict,
    input  logic [31:0]           ex_target,
    input  logic                  if_stall_req,
    input  logic                  mem_stall_req,
    input  logic                  if_redirect_ack,
    output logic [4:0]            stall,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      load_use_cnt
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } state_e;

    state_e                state_q, state_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;
    logic                  sb_valid_q, sb_valid_d;
    logic [REG_ADDR_W-1:0] sb_rd_q, sb_rd_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]      load_use_cnt_q, load_use_cnt_d;
    logic                  hazard;
    logic                  lu_event;

    // ID reads the register a load currently in EX will write; x0 never enters the scoreboard
    assign hazard = sb_valid_q & id_valid &
                    ((id_rs1_request & (id_rs1_addr == sb_rd_q)) |
                     (id_rs2_request & (id_rs2_addr == sb_rd_q)));

    // Priority-ordered stall/flush decode plus redirect FSM next state
    always_comb begin
        stall            = 5'b00000;
        flush_ifid       = 1'b0;
        flush_idex       = 1'b0;
        lu_event         = 1'b0;
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        if (mem_stall_req) begin
            // whole pipe frozen; a mispredict in EX stays put and is taken later
            stall = 5'b11111;
        end else if (state_q == ST_RUN && ex_mispredict) begin
            flush_ifid       = 1'b1;
            flush_idex       = 1'b1;
            state_d          = ST_REDIRECT;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = ex_target;
        end else if (state_q == ST_REDIRECT) begin
            stall      = 5'b00001;
            flush_ifid = 1'b1;
        end else if (hazard) begin
            stall      = 5'b00011;
            flush_idex = 1'b1;
            lu_event   = 1'b1;
        end else if (if_stall_req) begin
            stall      = 5'b00001;
            flush_ifid = 1'b1;
        end

        if (state_q == ST_REDIRECT && redirect_valid_q && if_redirect_ack) begin
            state_d          = ST_RUN;
            redirect_valid_d = 1'b0;
        end
    end

    // Scoreboard follows the ID/EX register; the load-use bubble clears it so each hazard costs one cycle
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_rd_d    = sb_rd_q;
        if (!stall[2]) begin
            sb_valid_d = flush_idex ? 1'b0
                       : (id_valid & id_rd_load & id_rd_write & (id_rd_addr != '0));
            sb_rd_d    = id_rd_addr;
        end
    end

    // Watchdog count, sticky timeout flag and saturating load-use counter
    always_comb begin
        wd_cnt_d = '0;
        if (mem_stall_req) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        mem_timeout_d  = mem_timeout_q | (wd_cnt_d == WD_MAX);
        load_use_cnt_d = load_use_cnt_q;
        if (lu_event && (load_use_cnt_q != '1)) begin
            load_use_cnt_d = load_use_cnt_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            sb_valid_q       <= 1'b0;
            sb_rd_q          <= '0;
            wd_cnt_q         <= '0;
            mem_timeout_q    <= 1'b0;
            load_use_cnt_q   <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            sb_valid_q       <= sb_valid_d;
            sb_rd_q          <= sb_rd_d;
            wd_cnt_q         <= wd_cnt_d;
            mem_timeout_q    <= mem_timeout_d;
            load_use_cnt_q   <= load_use_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mem_timeout    = mem_timeout_q;
    assign load_use_cnt   = load_use_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, rs1_req, rs2_req, rd_write, rd_load;
    logic [4:0]  rs1, rs2, rd;
    logic        mis, ifs, mems, ack;
    logic [31:0] tgt;

    logic [4:0]  stall, stall2;
    logic        fifd, fidx, rv, tmo_o, fifd2, fidx2, rv2, tmo2;
    logic [31:0] rpc, rpc2;
    logic [15:0] cnt_o;
    logic [1:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    bit          m_redir;
    logic [31:0] m_pc;
    bit          sb_v;
    logic [4:0]  sb_rd;
    int          wd;
    bit          m_tmo;
    int          m_cnt;

    // last sampled DUT values, for directed checks
    logic [4:0]  o_stall;
    logic        o_fifd, o_fidx, o_rv, o_tmo;
    logic [31:0] o_pc;
    logic [15:0] o_cnt;
    logic [1:0]  o_cnt2;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_request(rs1_req), .id_rs1_addr(rs1),
        .id_rs2_request(rs2_req), .id_rs2_addr(rs2),
        .id_rd_addr(rd), .id_rd_write(rd_write), .id_rd_load(rd_load),
        .ex_mispredict(mis), .ex_target(tgt), .if_stall_req(ifs),
        .mem_stall_req(mems), .if_redirect_ack(ack),
        .stall(stall), .flush_ifid(fifd), .flush_idex(fidx),
        .redirect_valid(rv), .redirect_pc(rpc), .mem_timeout(tmo_o),
        .load_use_cnt(cnt_o)
    );

    pipe_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_request(rs1_req), .id_rs1_addr(rs1),
        .id_rs2_request(rs2_req), .id_rs2_addr(rs2),
        .id_rd_addr(rd), .id_rd_write(rd_write), .id_rd_load(rd_load),
        .ex_mispredict(mis), .ex_target(tgt), .if_stall_req(ifs),
        .mem_stall_req(mems), .if_redirect_ack(ack),
        .stall(stall2), .flush_ifid(fifd2), .flush_idex(fidx2),
        .redirect_valid(rv2), .redirect_pc(rpc2), .mem_timeout(tmo2),
        .load_use_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; rs1_req = 0; rs2_req = 0; rd_write = 0; rd_load = 0;
        rs1 = 0; rs2 = 0; rd = 0; mis = 0; ifs = 0; mems = 0; ack = 0; tgt = 0;
    endtask

    task automatic model_reset();
        m_redir = 0; m_pc = 0; sb_v = 0; sb_rd = 0; wd = 0; m_tmo = 0; m_cnt = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one clock
    task automatic cycle();
        logic [4:0] es;
        bit efi, efx, hz, lu;
        int sat16, sat2;
        hz = sb_v && id_valid && ((rs1_req && rs1 == sb_rd) || (rs2_req && rs2 == sb_rd));
        es = 5'd0; efi = 0; efx = 0; lu = 0;
        if (mems)                begin es = 5'b11111; end
        else if (!m_redir && mis) begin efi = 1; efx = 1; end
        else if (m_redir)        begin es = 5'b00001; efi = 1; end
        else if (hz)             begin es = 5'b00011; efx = 1; lu = 1; end
        else if (ifs)            begin es = 5'b00001; efi = 1; end
        sat16 = (m_cnt > 65535) ? 65535 : m_cnt;
        sat2  = (m_cnt > 3) ? 3 : m_cnt;
        #1;
        check("stall", 32'(stall), 32'(es));
        check("flush_ifid", 32'(fifd), 32'(efi));
        check("flush_idex", 32'(fidx), 32'(efx));
        check("redirect_valid", 32'(rv), 32'(m_redir));
        check("redirect_pc", rpc, m_pc);
        check("mem_timeout", 32'(tmo_o), 32'(m_tmo));
        check("load_use_cnt", 32'(cnt_o), 32'(sat16));
        check("stall_w2", 32'(stall2), 32'(es));
        check("flush_ifid_w2", 32'(fifd2), 32'(efi));
        check("flush_idex_w2", 32'(fidx2), 32'(efx));
        check("redirect_valid_w2", 32'(rv2), 32'(m_redir));
        check("redirect_pc_w2", rpc2, m_pc);
        check("mem_timeout_w2", 32'(tmo2), 32'(m_tmo));
        check("load_use_cnt_w2", 32'(cnt2), 32'(sat2));
        o_stall = stall; o_fifd = fifd; o_fidx = fidx; o_rv = rv; o_pc = rpc;
        o_tmo = tmo_o; o_cnt = cnt_o; o_cnt2 = cnt2;
        @(posedge clk);
        if (!mems && !m_redir && mis) begin m_redir = 1; m_pc = tgt; end
        else if (m_redir && ack) m_redir = 0;
        if (!es[2]) begin
            sb_v  = !efx && id_valid && rd_load && rd_write && (rd != 0);
            sb_rd = rd;
        end
        wd = mems ? ((wd < TMO) ? wd + 1 : TMO) : 0;
        if (wd == TMO) m_tmo = 1;
        if (lu) m_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        check("rst_redirect_valid", 32'(rv), 32'd0);
        check("rst_mem_timeout", 32'(tmo_o), 32'd0);
        check("rst_load_use_cnt", 32'(cnt_o), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic put_load(input logic [4:0] r);
        idle(); id_valid = 1; rd = r; rd_write = 1; rd_load = 1;
    endtask

    task automatic put_use(input logic [4:0] r);
        idle(); id_valid = 1; rs1_req = 1; rs1 = r; rd = 6; rd_write = 1;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd6};
        return regs[$urandom_range(0, 3)];
    endfunction

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // load-use on x5, one bubble then go
        put_load(5); cycle();
        put_use(5);  cycle();
        check("lu_stall", 32'(o_stall), 32'h03);
        check("lu_flush_idex", 32'(o_fidx), 32'd1);
        cycle();
        check("lu_release", 32'(o_stall), 32'h00);
        check("lu_cnt", 32'(o_cnt), 32'd1);
        // x0 destination never hazards
        put_load(0); cycle();
        put_use(0);  cycle();
        check("x0_nostall", 32'(o_stall), 32'h00);

        // mispredict with delayed ack
        idle(); mis = 1; tgt = 32'h0000_1040; cycle();
        check("mp_flush", 32'({o_fifd, o_fidx}), 32'h3);
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mp_rv", 32'(o_rv), 32'd1);
            check("mp_pc", o_pc, 32'h0000_1040);
            check("mp_stall", 32'(o_stall), 32'h01);
        end
        ack = 1; cycle();
        idle(); cycle();
        check("mp_back_run", 32'(o_rv), 32'd0);

        // mispredict held back by mem stall
        idle(); mis = 1; mems = 1; tgt = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("mpm_stall", 32'(o_stall), 32'h1f);
            check("mpm_norv", 32'(o_rv), 32'd0);
        end
        mems = 0; cycle();
        check("mpm_flush", 32'({o_fifd, o_fidx}), 32'h3);
        idle(); cycle();
        check("mpm_rv", 32'(o_rv), 32'd1);
        ack = 1; cycle();
        idle(); cycle();

        // if_stall loses to load-use
        put_load(7); cycle();
        put_use(7); ifs = 1; cycle();
        check("prio_stall", 32'(o_stall), 32'h03);
        check("prio_flush", 32'({o_fifd, o_fidx}), 32'h1);
        idle(); cycle();

        // watchdog
        idle(); mems = 1;
        for (int i = 0; i < TMO; i++) cycle();
        check("wd_before", 32'(o_tmo), 32'd0);
        mems = 0; cycle();
        check("wd_set", 32'(o_tmo), 32'd1);
        cycle();
        check("wd_sticky", 32'(o_tmo), 32'd1);
        do_reset();

        // saturation on the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            put_load(9); cycle();
            put_use(9);  cycle();
        end
        idle(); cycle();
        check("sat_w2", 32'(o_cnt2), 32'd3);
        check("sat_w16", 32'(o_cnt), 32'd5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            rs1_req  = $urandom_range(0, 1);
            rs2_req  = $urandom_range(0, 1);
            rs1      = pick_reg();
            rs2      = pick_reg();
            rd       = pick_reg();
            rd_write = ($urandom_range(0, 3) != 0);
            rd_load  = $urandom_range(0, 1);
            mis      = ($urandom_range(0, 9) == 0);
            tgt      = $urandom;
            ifs      = ($urandom_range(0, 4) == 0);
            mems     = ($urandom_range(0, 7) == 0);
            ack      = ($urandom_range(0, 2) == 0);
            cycle();
            if (i == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It takes decode-stage register usage, the EX-stage branch resolution and the fetch/memory busy requests. From these it drives per-stage stall and flush controls and a PC redirect handshake toward IF. It holds a one-entry load-use scoreboard for the instruction in EX, a memory-stall watchdog, and a saturating load-use event counter.

Parameters:
REG_ADDR_W, 5, register address width
MEM_TIMEOUT, 64, consecutive mem_stall_req cycles before mem_timeout sets
CNT_W, 16, width of load_use_cnt

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1_request  in  1  ID reads rs1
id_rs1_addr  in  REG_ADDR_W  rs1 index
id_rs2_request  in  1  ID reads rs2
id_rs2_addr  in  REG_ADDR_W  rs2 index
id_rd_addr  in  REG_ADDR_W  rd index
id_rd_write  in  1  ID writes rd
id_rd_load  in  1  ID instruction is a load
ex_mispredict  in  1  EX resolved a branch/jump against the prediction
ex_target  in  32  correct next PC from EX
if_stall_req  in  1  fetch cannot deliver this cycle
mem_stall_req  in  1  MEM access not finished
if_redirect_ack  in  1  IF accepted redirect_pc
stall  out  5  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB; 1 = hold register
flush_ifid  out  1  load bubble into IF/ID
flush_idex  out  1  load bubble into ID/EX
redirect_valid  out  1  registered; redirect request pending
redirect_pc  out  32  registered target
mem_timeout  out  1  sticky watchdog error
load_use_cnt  out  CNT_W  saturating load-use bubble count

Behaviour:
- Reset (async, rst_n=0): state=RUN; redirect_valid=0; redirect_pc=0; scoreboard valid=0, rd=0; watchdog count=0; mem_timeout=0; load_use_cnt=0. Combinational outputs follow from this state with stall=0 and flush=0 when inputs are idle. Reset mid-redirect drops the redirect with no ack required.
- FSM states: RUN, REDIRECT.
- Combinational priority, evaluated each cycle:
  1. mem_stall_req=1 → stall=5'b11111, no flush. ex_mispredict, load-use and if_stall_req are ignored this cycle. EX is frozen, so a mispredict re-presents itself later.
  2. In RUN, ex_mispredict=1 → stall=0, flush_ifid=1, flush_idex=1. Next edge: redirect_pc<=ex_target, redirect_valid<=1, state<=REDIRECT.
  3. In REDIRECT → stall[0]=1, flush_ifid=1, flush_idex=0, stall[4:1]=0. ex_mispredict is ignored (EX holds a bubble). When redirect_valid & if_redirect_ack: next edge redirect_valid<=0, state<=RUN. redirect_pc is stable while redirect_valid=1.
  4. In RUN, load-use hazard → stall[1:0]=2'b11, flush_idex=1, stall[4:2]=0; load_use_cnt increments, saturating at all-ones. Hazard = sb_valid & id_valid & ((id_rs1_request & id_rs1_addr==sb_rd) | (id_rs2_request & id_rs2_addr==sb_rd)).
  5. In RUN, if_stall_req → stall[0]=1, flush_ifid=1, others 0.
  6. Otherwise stall=0, no flush.
- Scoreboard: updates only on edges where stall[2]=0.
  - sb_valid <= flush_idex ? 0 : (id_valid & id_rd_load & id_rd_write & id_rd_addr!=0); sb_rd <= id_rd_addr.
  - The bubble inserted for a load-use clears sb_valid, so each hazard costs exactly 1 cycle (MEM→EX forwarding covers the rest).
  - x0 never hazards.
- Watchdog: count increments while mem_stall_req=1 and clears when it is 0, saturating at MEM_TIMEOUT. mem_timeout sets on the edge where count reaches MEM_TIMEOUT and stays set until reset. Pipeline behaviour is unaffected.
- Latency: stall/flush are combinational, same cycle. redirect_valid rises 1 cycle after the mispredict is accepted.

Test Plan:
- Load-use: `lw x5` enters EX (sb_rd=5), next ID is `add x6,x5,x1` with rs1_request=1 → 1 cycle of stall=5'b00011, flush_idex=1, load_use_cnt=1, then stall=0. Repeat with rd=x0 → no stall.
- Mispredict: ex_mispredict=1, ex_target=0x0000_1040 → flushes that cycle. Next cycle redirect_valid=1, redirect_pc=0x1040, stall[0]=1. Hold if_redirect_ack=0 for 3 cycles (outputs stable), then ack → RUN one edge later.
- Mispredict under mem stall: mem_stall_req=1 and ex_mispredict=1 for 4 cycles → stall=5'b11111, no redirect. mem_stall_req drops → redirect sequence starts that cycle.
- Priority: if_stall_req=1 together with a load-use hazard → load-use response (stall=5'b00011, flush_idex=1, flush_ifid=0).
- Watchdog: mem_stall_req=1 for 64 cycles → mem_timeout=1 after the 64th edge. Drop the request → mem_timeout stays 1. Assert rst_n=0 → mem_timeout=0, redirect_valid=0 asynchronously.
- Counter saturation: with CNT_W=2, 5 hazards → load_use_cnt=3.
